ahb_master_arbiter: RTL and testbench
=====================================

Name: ahb_master_arbiter

Overview:
Two-master AHB-Lite arbiter placed in front of ahb_interconnect slave port s0. It lets cpu_core (M0) and a future frame-DMA master (M1) share the single bus. It owns the request/grant handshake, muxes the address phase from the address-phase owner, and muxes hwdata from the data-phase owner. Handover happens only at safe IDLE boundaries, with an optional tenure limit to prevent starvation.

Parameters:
RR_MODE, 0, 0 = fixed priority (M0 wins); 1 = round-robin (alternate on contention)
MAX_TENURE, 16, cycles the owner may hold the grant while the other master requests; 0 = unlimited
CNT_W, 8, width of the tenure counter; must satisfy MAX_TENURE < 2^CNT_W

Ports:
clk  in  1  system clock (clk_int domain)
resetn  in  1  reset
m0_req_i / m1_req_i  in  1  bus request from M0 / M1
m0_gnt_o / m1_gnt_o  out  1  grant to M0 / M1; exactly one is high at all times
m{0,1}_haddr_i  in  32  master address
m{0,1}_hwrite_i  in  1  master write flag
m{0,1}_hsize_i  in  3  master transfer size
m{0,1}_hburst_i  in  3  master burst type
m{0,1}_hprot_i  in  4  master protection
m{0,1}_htrans_i  in  2  master transfer type
m{0,1}_hmastlock_i  in  1  master lock
m{0,1}_hwdata_i  in  32  master write data
m_hready_o  out  1  broadcast to both masters; equals s_hready_i
m_hresp_o  out  1  broadcast; equals s_hresp_i
m_hrdata_o  out  32  broadcast; equals s_hrdata_i
s_haddr_o, s_hwrite_o, s_hsize_o, s_hburst_o, s_hprot_o, s_htrans_o, s_hmastlock_o  out  32/1/3/3/4/2/1  address phase to interconnect
s_hwdata_o  out  32  write data to interconnect
s_hready_i  in  1  interconnect ready
s_hresp_i  in  1  interconnect response
s_hrdata_i  in  32  interconnect read data
hmaster_o  out  1  current address-phase owner
hmaster_data_o  out  1  current data-phase owner

Behaviour:
- Reset and clock: resetn is asynchronous, active-low; clock is clk. All flops use posedge clk, negedge resetn.
- Reset values: gnt = M0 (m0_gnt_o=1, m1_gnt_o=0), hmaster_o=0, hmaster_data_o=0, tenure count=0.
- State: registered owner bit. State OWN0 drives m0_gnt_o; state OWN1 drives m1_gnt_o. With no requests the grant parks on the last owner.
- Address mux (combinational): all s_* address-phase outputs come from master[hmaster_o]. The non-owner's htrans is ignored.
- Data mux (combinational): s_hwdata_o = m{hmaster_data_o}_hwdata_i.
- Data owner update: hmaster_data_o <= hmaster_o on every cycle with s_hready_i=1. It holds through wait states.
- Response path: broadcast combinationally with zero latency. Masters qualify responses with their own grant/data ownership.
- Handover eligibility, evaluated each cycle; all must hold:
  - s_hready_i=1
  - owner htrans == IDLE (2'b00)
  - owner hmastlock=0
  - other master's req=1
- Switch condition, given eligibility:
  - owner req=0 → switch.
  - Tenure expired (MAX_TENURE>0 and count>=MAX_TENURE) → switch.
  - RR_MODE=1, both requesting → switch.
  - RR_MODE=0, both requesting → switch only if other == M0.
- Switch timing: owner toggles at the next edge, and the grant outputs change in the same edge. The new master drives its first NONSEQ the cycle after it sees its grant.
- Outside an eligible cycle (BUSY/SEQ/NONSEQ, hready low, or locked) the owner is held, with no exceptions.
- Tenure counter:
  - Resets to 0 on handover, or whenever the other req=0.
  - Otherwise increments each cycle the owner holds the grant, saturating at 2^CNT_W-1.
- Simultaneous events:
  - Eligibility and tenure expiry in the same cycle → switch.
  - Request deassert and re-assert on the same edge as a handover do not cancel the handover.
- No double grant: the two gnt outputs are complementary by construction.
- hresp ERROR: no special handling. The owner is expected to issue IDLE, which is itself an eligible boundary.
- Reset mid-transfer: all state returns to reset values immediately; in-flight data phase is abandoned.

Test Plan:
1. Reset, then M0 issues NONSEQ write to 0x0000_0100 → m0_gnt_o=1, s_haddr_o=0x100, s_htrans_o=2'b10; next hready cycle s_hwdata_o = m0_hwdata_i.
2. RR_MODE=0: M1 owns, both request, M1 drives IDLE with hready=1 → on next edge m0_gnt_o=1 and hmaster_o=0; hmaster_data_o flips one hready cycle later.
3. M1 write in data phase with s_hready_i low 3 cycles, M0 requesting → no switch; s_hwdata_o stays M1 data until hready=1.
4. M0 hmastlock=1 with IDLE cycles, M1 requesting 40 cycles → grant stays M0; switch occurs on first IDLE after hmastlock drops.
5. MAX_TENURE=4: M0 requests continuously with IDLE every cycle, M1 requests → m1_gnt_o=1 within 5 cycles of M1 req.
6. Assert resetn=0 during M1 SEQ burst → gnt=M0, hmaster_o=0, hmaster_data_o=0 asynchronously.

Source files
------------

// File: rtl/ahb_master_arbiter.sv
// Two-master AHB-Lite arbiter in front of interconnect slave port s0.
// Hands the bus over only on unlocked IDLE boundaries, with an optional tenure limit.
module ahb_master_arbiter #(
  parameter bit          RR_MODE    = 1'b0,
  parameter int unsigned MAX_TENURE = 32'd16,
  parameter int unsigned CNT_W      = 32'd8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_req_i,
  input  logic        m1_req_i,
  output logic        m0_gnt_o,
  output logic        m1_gnt_o,
  input  logic [31:0] m0_haddr_i,
  input  logic        m0_hwrite_i,
  input  logic [2:0]  m0_hsize_i,
  input  logic [2:0]  m0_hburst_i,
  input  logic [3:0]  m0_hprot_i,
  input  logic [1:0]  m0_htrans_i,
  input  logic        m0_hmastlock_i,
  input  logic [31:0] m0_hwdata_i,
  input  logic [31:0] m1_haddr_i,
  input  logic        m1_hwrite_i,
  input  logic [2:0]  m1_hsize_i,
  input  logic [2:0]  m1_hburst_i,
  input  logic [3:0]  m1_hprot_i,
  input  logic [1:0]  m1_htrans_i,
  input  logic        m1_hmastlock_i,
  input  logic [31:0] m1_hwdata_i,
  output logic        m_hready_o,
  output logic        m_hresp_o,
  output logic [31:0] m_hrdata_o,
  output logic [31:0] s_haddr_o,
  output logic        s_hwrite_o,
  output logic [2:0]  s_hsize_o,
  output logic [2:0]  s_hburst_o,
  output logic [3:0]  s_hprot_o,
  output logic [1:0]  s_htrans_o,
  output logic        s_hmastlock_o,
  output logic [31:0] s_hwdata_o,
  input  logic        s_hready_i,
  input  logic        s_hresp_i,
  input  logic [31:0] s_hrdata_i,
  output logic        hmaster_o,
  output logic        hmaster_data_o
);

  typedef enum logic {OWN0 = 1'b0, OWN1 = 1'b1} own_e;

  localparam logic [1:0]       HTRANS_IDLE = 2'b00;
  localparam bit               TENURE_EN   = (MAX_TENURE != 32'd0);
  localparam logic [CNT_W-1:0] TENURE_LIM  = CNT_W'(MAX_TENURE);
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  own_e             owner_r;
  logic             data_owner_r;
  logic [CNT_W-1:0] tenure_r;

  logic       own_req_s;
  logic       oth_req_s;
  logic [1:0] own_htrans_s;
  logic       own_lock_s;
  logic       eligible_s;
  logic       expired_s;
  logic       switch_s;

  // Owner-side view of the request lines plus the address-phase mux
  always_comb begin
    own_req_s     = m0_req_i;
    oth_req_s     = m1_req_i;
    own_htrans_s  = m0_htrans_i;
    own_lock_s    = m0_hmastlock_i;
    s_haddr_o     = m0_haddr_i;
    s_hwrite_o    = m0_hwrite_i;
    s_hsize_o     = m0_hsize_i;
    s_hburst_o    = m0_hburst_i;
    s_hprot_o     = m0_hprot_i;
    s_htrans_o    = m0_htrans_i;
    s_hmastlock_o = m0_hmastlock_i;
    case (owner_r)
      OWN1: begin
        own_req_s     = m1_req_i;
        oth_req_s     = m0_req_i;
        own_htrans_s  = m1_htrans_i;
        own_lock_s    = m1_hmastlock_i;
        s_haddr_o     = m1_haddr_i;
        s_hwrite_o    = m1_hwrite_i;
        s_hsize_o     = m1_hsize_i;
        s_hburst_o    = m1_hburst_i;
        s_hprot_o     = m1_hprot_i;
        s_htrans_o    = m1_htrans_i;
        s_hmastlock_o = m1_hmastlock_i;
      end
      default: begin
        own_req_s = m0_req_i;
      end
    endcase
  end

  assign eligible_s = s_hready_i && (own_htrans_s == HTRANS_IDLE) && !own_lock_s && oth_req_s;
  assign expired_s  = TENURE_EN && (tenure_r >= TENURE_LIM);

  // Handover decision; under fixed priority M1 only loses to M0 on contention
  always_comb begin
    switch_s = 1'b0;
    if (eligible_s) begin
      if (!own_req_s || expired_s || RR_MODE) begin
        switch_s = 1'b1;
      end else begin
        switch_s = (owner_r == OWN1);
      end
    end else begin
      switch_s = 1'b0;
    end
  end

  // Owner FSM, data-phase owner tracking and saturating tenure counter
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      owner_r      <= OWN0;
      data_owner_r <= 1'b0;
      tenure_r     <= '0;
    end else begin
      if (s_hready_i) begin
        data_owner_r <= owner_r;
      end
      case (owner_r)
        OWN0:    if (switch_s) owner_r <= OWN1;
        OWN1:    if (switch_s) owner_r <= OWN0;
        default: owner_r <= OWN0;
      endcase
      if (switch_s || !oth_req_s) begin
        tenure_r <= '0;
      end else if (tenure_r != CNT_MAX) begin
        tenure_r <= tenure_r + CNT_ONE;
      end
    end
  end

  // Grants derive from the single owner flop, so they can never both be high
  assign m0_gnt_o       = (owner_r == OWN0);
  assign m1_gnt_o       = (owner_r == OWN1);
  assign hmaster_o      = owner_r;
  assign hmaster_data_o = data_owner_r;
  assign s_hwdata_o     = data_owner_r ? m1_hwdata_i : m0_hwdata_i;

  assign m_hready_o = s_hready_i;
  assign m_hresp_o  = s_hresp_i;
  assign m_hrdata_o = s_hrdata_i;

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Directed bench: three arbiter instances share stimulus. Instance 0 is fixed priority with
// tenure 16, instance 1 is fixed priority with tenure 4, instance 2 is round-robin, unlimited.
module tb_ahb_master_arbiter;
  logic clk = 1'b0;
  logic resetn;
  logic m0_req, m1_req;
  logic [31:0] m0_haddr, m1_haddr, m0_hwdata, m1_hwdata;
  logic m0_hwrite, m1_hwrite, m0_hmastlock, m1_hmastlock;
  logic [2:0] m0_hsize, m1_hsize, m0_hburst, m1_hburst;
  logic [3:0] m0_hprot, m1_hprot;
  logic [1:0] m0_htrans, m1_htrans;
  logic s_hready, s_hresp;
  logic [31:0] s_hrdata;

  logic [2:0] m0_gnt, m1_gnt, m_hready, m_hresp, s_hwrite, s_hmastlock, hmaster, hmaster_data;
  logic [31:0] m_hrdata [3];
  logic [31:0] s_haddr [3];
  logic [31:0] s_hwdata [3];
  logic [2:0] s_hsize [3];
  logic [2:0] s_hburst [3];
  logic [3:0] s_hprot [3];
  logic [1:0] s_htrans [3];

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ahb_master_arbiter #(
      .RR_MODE    (g == 2),
      .MAX_TENURE ((g == 0) ? 16 : ((g == 1) ? 4 : 0)),
      .CNT_W      (8)
    ) dut (
      .clk(clk), .resetn(resetn),
      .m0_req_i(m0_req), .m1_req_i(m1_req),
      .m0_gnt_o(m0_gnt[g]), .m1_gnt_o(m1_gnt[g]),
      .m0_haddr_i(m0_haddr), .m0_hwrite_i(m0_hwrite), .m0_hsize_i(m0_hsize),
      .m0_hburst_i(m0_hburst), .m0_hprot_i(m0_hprot), .m0_htrans_i(m0_htrans),
      .m0_hmastlock_i(m0_hmastlock), .m0_hwdata_i(m0_hwdata),
      .m1_haddr_i(m1_haddr), .m1_hwrite_i(m1_hwrite), .m1_hsize_i(m1_hsize),
      .m1_hburst_i(m1_hburst), .m1_hprot_i(m1_hprot), .m1_htrans_i(m1_htrans),
      .m1_hmastlock_i(m1_hmastlock), .m1_hwdata_i(m1_hwdata),
      .m_hready_o(m_hready[g]), .m_hresp_o(m_hresp[g]), .m_hrdata_o(m_hrdata[g]),
      .s_haddr_o(s_haddr[g]), .s_hwrite_o(s_hwrite[g]), .s_hsize_o(s_hsize[g]),
      .s_hburst_o(s_hburst[g]), .s_hprot_o(s_hprot[g]), .s_htrans_o(s_htrans[g]),
      .s_hmastlock_o(s_hmastlock[g]), .s_hwdata_o(s_hwdata[g]),
      .s_hready_i(s_hready), .s_hresp_i(s_hresp), .s_hrdata_i(s_hrdata),
      .hmaster_o(hmaster[g]), .hmaster_data_o(hmaster_data[g])
    );
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    m0_req = 1'b0; m1_req = 1'b0;
    m0_haddr = 32'h0; m1_haddr = 32'h0; m0_hwdata = 32'h0; m1_hwdata = 32'h0;
    m0_hwrite = 1'b0; m1_hwrite = 1'b0; m0_hmastlock = 1'b0; m1_hmastlock = 1'b0;
    m0_hsize = 3'd0; m1_hsize = 3'd0; m0_hburst = 3'd0; m1_hburst = 3'd0;
    m0_hprot = 4'd0; m1_hprot = 4'd0; m0_htrans = 2'b00; m1_htrans = 2'b00;
    s_hready = 1'b1; s_hresp = 1'b0; s_hrdata = 32'h0;
    step();
    step();
    resetn = 1'b1;
    #1;
  endtask

  // Hand the bus to M1 on every instance: M0 idle and not requesting
  task automatic give_m1();
    m0_req = 1'b0; m1_req = 1'b1; m0_htrans = 2'b00; s_hready = 1'b1;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    s_hrdata = 32'hCAFE_F00D; s_hresp = 1'b1; s_hready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if ({m0_gnt[i], m1_gnt[i], hmaster[i], hmaster_data[i]} !== 4'b1000) begin
        $display("FAIL reset_state[%0d]: got gnt0/gnt1/hm/hmd=%b expected 1000", i,
                 {m0_gnt[i], m1_gnt[i], hmaster[i], hmaster_data[i]});
        tests_failed++;
      end
      tests_run++;
      if ({m_hready[i], m_hresp[i], m_hrdata[i]} !== {1'b0, 1'b1, 32'hCAFE_F00D}) begin
        $display("FAIL resp_broadcast[%0d]: got %b %b %h expected 0 1 cafef00d", i,
                 m_hready[i], m_hresp[i], m_hrdata[i]);
        tests_failed++;
      end
    end
  endtask

  task automatic test_m0_write();
    do_reset();
    m0_req = 1'b1; m0_haddr = 32'h0000_0100; m0_htrans = 2'b10; m0_hwrite = 1'b1;
    m0_hsize = 3'd2; m0_hburst = 3'd1; m0_hprot = 4'h3;
    m1_haddr = 32'h0000_0BAD; m1_htrans = 2'b10; m1_hwdata = 32'h5555_AAAA;
    #1;
    tests_run++;
    if ({m0_gnt[0], s_haddr[0], s_htrans[0], s_hwrite[0]} !== {1'b1, 32'h0000_0100, 2'b10, 1'b1}) begin
      $display("FAIL m0_addr_phase: got gnt=%b addr=%h trans=%b wr=%b expected 1 00000100 10 1",
               m0_gnt[0], s_haddr[0], s_htrans[0], s_hwrite[0]);
      tests_failed++;
    end
    tests_run++;
    if ({s_hsize[0], s_hburst[0], s_hprot[0], s_hmastlock[0]} !== {3'd2, 3'd1, 4'h3, 1'b0}) begin
      $display("FAIL m0_ctrl_mux: got %h %h %h %b expected 2 1 3 0",
               s_hsize[0], s_hburst[0], s_hprot[0], s_hmastlock[0]);
      tests_failed++;
    end
    step();
    m0_htrans = 2'b00; m0_hwdata = 32'hDEAD_BEEF;
    #1;
    tests_run++;
    if (s_hwdata[0] !== 32'hDEAD_BEEF) begin
      $display("FAIL m0_wdata: got %h expected deadbeef", s_hwdata[0]);
      tests_failed++;
    end
  endtask

  task automatic test_priority_handback();
    do_reset();
    give_m1();
    tests_run++;
    if ({m1_gnt[0], hmaster[0], hmaster_data[0]} !== 3'b110) begin
      $display("FAIL m1_takeover: got gnt1/hm/hmd=%b expected 110", {m1_gnt[0], hmaster[0], hmaster_data[0]});
      tests_failed++;
    end
    m0_req = 1'b1; m1_req = 1'b1; m1_htrans = 2'b00;
    step();
    tests_run++;
    if ({m0_gnt[0], hmaster[0], hmaster_data[0]} !== 3'b101) begin
      $display("FAIL prio_handback: got gnt0/hm/hmd=%b expected 101", {m0_gnt[0], hmaster[0], hmaster_data[0]});
      tests_failed++;
    end
    step();
    tests_run++;
    if (hmaster_data[0] !== 1'b0) begin
      $display("FAIL data_owner_follow: got %b expected 0", hmaster_data[0]);
      tests_failed++;
    end
  endtask

  task automatic test_wait_states();
    int bad;
    do_reset();
    give_m1();
    m0_req = 1'b1; m1_htrans = 2'b10; m1_hwrite = 1'b1; m1_haddr = 32'h0000_0200;
    step();
    m1_htrans = 2'b00; s_hready = 1'b0;
    m1_hwdata = 32'h1111_2222; m0_hwdata = 32'h3333_4444;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (m1_gnt[0] !== 1'b1 || hmaster[0] !== 1'b1 || s_hwdata[0] !== 32'h1111_2222) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      $display("FAIL wait_hold: got %0d bad cycles expected 0 (last gnt1=%b wdata=%h)", bad, m1_gnt[0], s_hwdata[0]);
      tests_failed++;
    end
    s_hready = 1'b1;
    step();
    tests_run++;
    if ({m0_gnt[0], hmaster_data[0], s_hwdata[0]} !== {1'b1, 1'b1, 32'h1111_2222}) begin
      $display("FAIL wait_release: got gnt0=%b hmd=%b wdata=%h expected 1 1 11112222",
               m0_gnt[0], hmaster_data[0], s_hwdata[0]);
      tests_failed++;
    end
  endtask

  task automatic test_lock();
    int bad;
    do_reset();
    m0_req = 1'b1; m0_hmastlock = 1'b1; m0_htrans = 2'b00; m1_req = 1'b1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (m0_gnt[0] !== 1'b1) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      $display("FAIL lock_hold: got %0d cycles without m0 grant expected 0", bad);
      tests_failed++;
    end
    m0_hmastlock = 1'b0; m0_htrans = 2'b10;
    step();
    tests_run++;
    if (m0_gnt[0] !== 1'b1) begin
      $display("FAIL unlock_nonseq_hold: got gnt0=%b expected 1", m0_gnt[0]);
      tests_failed++;
    end
    m0_htrans = 2'b00;
    step();
    tests_run++;
    if (m1_gnt[0] !== 1'b1) begin
      $display("FAIL unlock_idle_switch: got gnt1=%b expected 1", m1_gnt[0]);
      tests_failed++;
    end
  endtask

  task automatic test_tenure();
    do_reset();
    m0_req = 1'b1; m0_htrans = 2'b00;
    step();
    step();
    m1_req = 1'b1;
    for (int i = 0; i < 4; i++) step();
    tests_run++;
    if (m1_gnt[1] !== 1'b0) begin
      $display("FAIL tenure_early: got gnt1=%b after 4 cycles expected 0", m1_gnt[1]);
      tests_failed++;
    end
    step();
    tests_run++;
    if (m1_gnt[1] !== 1'b1) begin
      $display("FAIL tenure_expire: got gnt1=%b after 5 cycles expected 1", m1_gnt[1]);
      tests_failed++;
    end
    tests_run++;
    if (m0_gnt[0] !== 1'b1) begin
      $display("FAIL fixed_prio_hold: got gnt0=%b on tenure-16 instance expected 1", m0_gnt[0]);
      tests_failed++;
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] seq;
    do_reset();
    m0_req = 1'b1; m1_req = 1'b1; m0_htrans = 2'b00; m1_htrans = 2'b00;
    for (int i = 0; i < 3; i++) begin
      step();
      seq[i] = hmaster[2];
    end
    tests_run++;
    if (seq !== 3'b101) begin
      $display("FAIL rr_alternate: got hmaster seq (c2..c0)=%b expected 101", seq);
      tests_failed++;
    end
    tests_run++;
    if (hmaster[0] !== 1'b0) begin
      $display("FAIL fixed_no_alternate: got hmaster=%b expected 0", hmaster[0]);
      tests_failed++;
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    give_m1();
    m1_htrans = 2'b10; m1_hburst = 3'd3;
    step();
    m1_htrans = 2'b11;
    step();
    tests_run++;
    if ({hmaster[0], hmaster_data[0]} !== 2'b11) begin
      $display("FAIL burst_owner: got hm/hmd=%b expected 11", {hmaster[0], hmaster_data[0]});
      tests_failed++;
    end
    #2;
    resetn = 1'b0;
    #1;
    tests_run++;
    if ({m0_gnt[0], m1_gnt[0], hmaster[0], hmaster_data[0]} !== 4'b1000) begin
      $display("FAIL async_reset: got gnt0/gnt1/hm/hmd=%b expected 1000",
               {m0_gnt[0], m1_gnt[0], hmaster[0], hmaster_data[0]});
      tests_failed++;
    end
    resetn = 1'b1;
  endtask

  initial begin
    test_reset();
    test_m0_write();
    test_priority_handback();
    test_wait_states();
    test_lock();
    test_tenure();
    test_round_robin();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
